// File: rtl/finalsoc_pio_pkg.sv
// rtl/finalsoc_pio_pkg.sv - shared register map and edge-mode constants for the edge-capturing input PIO
package finalsoc_pio_pkg;

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_MASK    = 2'd1;
    localparam logic [1:0] ADDR_RSVD    = 2'd2;
    localparam logic [1:0] ADDR_CAPTURE = 2'd3;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/finalsoc_pio_edge_in_if.sv
// rtl/finalsoc_pio_edge_in_if.sv - Avalon-MM slave register bus of the edge-capturing input PIO
interface finalsoc_pio_edge_in_if;

    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata
    );

endinterface

// File: rtl/finalsoc_pio_bit_filter.sv
// rtl/finalsoc_pio_bit_filter.sv - per-bit synchroniser plus optional debouncer (FINALSOC_PIO_DEBOUNCE_EN)
module finalsoc_pio_bit_filter #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1000
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic filt
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_out;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
        end
    end

    assign sync_out = sync_q[SYNC_STAGES-1];

`ifdef FINALSOC_PIO_DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [CW-1:0] cnt;

    // cnt counts consecutive cycles the synchronised input disagrees with filt;
    // any return to the accepted value restarts the count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt  <= '0;
            filt <= 1'b0;
        end else if (sync_out == filt) begin
            cnt <= '0;
        end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
            cnt  <= '0;
            filt <= sync_out;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end
`else
    localparam int unused_debounce_cycles = DEBOUNCE_CYCLES;

    assign filt = sync_out;
`endif

endmodule

// File: rtl/finalsoc_pio_edge_in.sv
// rtl/finalsoc_pio_edge_in.sv - input PIO with edge capture, W1C register and maskable irq
// Optional debounce stage per bit is enabled with FINALSOC_PIO_DEBOUNCE_EN.
module finalsoc_pio_edge_in
    import finalsoc_pio_pkg::*;
#(
    parameter int WIDTH           = 8,
    parameter int SYNC_STAGES     = 2,
    parameter int EDGE_MODE       = 0,
    parameter int DEBOUNCE_CYCLES = 1000
) (
    input  logic                   clk,
    input  logic                   reset,
    finalsoc_pio_edge_in_if.slave  bus,
    input  logic [WIDTH-1:0]       in_port,
    output logic                   irq
);

    localparam int ARM_CYCLES = SYNC_STAGES + 1;
    localparam int AW         = $clog2(ARM_CYCLES + 1);

    logic [WIDTH-1:0] filt;
    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] mask;
    logic [WIDTH-1:0] cap;
    logic [WIDTH-1:0] edge_hit;
    logic [WIDTH-1:0] clr;
    logic [WIDTH-1:0] wd;
    logic [AW-1:0]    arm_cnt;
    logic             armed;
    logic             wr_en;
    logic [31:0]      rd_mux;
    logic             unused_writedata;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            finalsoc_pio_bit_filter #(
                .SYNC_STAGES     (SYNC_STAGES),
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
            ) u_filter (
                .clk   (clk),
                .reset (reset),
                .din   (in_port[gi]),
                .filt  (filt[gi])
            );
        end
    endgenerate

    assign wd               = bus.writedata[WIDTH-1:0];
    assign unused_writedata = ^bus.writedata;
    assign wr_en            = bus.chipselect && !bus.write_n;
    assign clr              = (wr_en && bus.address == ADDR_CAPTURE) ? wd : '0;

    // The chain powers up at 0, so a line already high would look like a rising
    // edge while the synchroniser fills; edges are held off until that has drained.
    assign armed = (arm_cnt == AW'(ARM_CYCLES));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            arm_cnt <= '0;
        end else if (!armed) begin
            arm_cnt <= arm_cnt + 1'b1;
        end
    end

    always_comb begin
        edge_hit = filt & ~prev;
        case (EDGE_MODE)
            EDGE_FALL: edge_hit = ~filt & prev;
            EDGE_ANY:  edge_hit = filt ^ prev;
            default:   edge_hit = filt & ~prev;
        endcase
        if (!armed) begin
            edge_hit = '0;
        end
    end

    always_comb begin
        rd_mux = '0;
        case (bus.address)
            ADDR_DATA:    rd_mux = 32'(filt);
            ADDR_MASK:    rd_mux = 32'(mask);
            ADDR_CAPTURE: rd_mux = 32'(cap);
            default:      rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev         <= '0;
            mask         <= '0;
            cap          <= '0;
            bus.readdata <= '0;
        end else begin
            prev <= filt;
            if (wr_en && bus.address == ADDR_MASK) begin
                mask <= wd;
            end
            // OR-ing the new edges in after the clear makes a same-cycle set win.
            cap          <= (cap & ~clr) | edge_hit;
            bus.readdata <= rd_mux;
        end
    end

    assign irq = |(cap & mask);

endmodule
